sweep_sequencer: RTL and testbench

- Sequences one frequency sweep of the impedance/phase measurement chain.
- For each table point it:
  - reads the NCO phase increment from the frequency ROM;
  - loads it into the sine generator and waits a settling time;
  - starts the phase/magnitude detector and waits for its result;
  - pulses the write enable that stores phase/modulo/moduloA/moduloB into the four result memories at the point's address.
- Sits between the start key and the Control_path datapath/result memories in the clk125 domain.

---
 rtl/sweep_sequencer_pkg.sv | 32 +++
 rtl/sweep_sequencer_cycle_timer.sv | 39 +++
 rtl/sweep_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sweep_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_sequencer_pkg.sv
// Shared types, defaults and the counter-width helper for the sweep sequencer.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SETTLE,
    MEAS,
    WRITE,
    NEXT,
    DONE
  } sweep_state_t;

  localparam int unsigned DEF_ADDR_WIDTH    = 8;
  localparam int unsigned DEF_INC_WIDTH     = 32;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_MEAS_TIMEOUT  = 65536;
  localparam int unsigned DEF_ROM_LATENCY   = 2;

  // Width of the shared wait counter: wide enough for the longest wait.
  function automatic int unsigned cnt_width(input int unsigned settle,
                                            input int unsigned timeout,
                                            input int unsigned rom_lat);
    int unsigned m;
    m = settle;
    if (timeout > m) m = timeout;
    if (rom_lat > m) m = rom_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sweep_sequencer_cycle_timer.sv
// Up-counter with terminal-count compare against a runtime limit.
// Cleared on every state entry; holds once the limit is reached.
module cycle_timer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             expired,
  output logic             first
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign expired = (count_q == limit);
  assign first   = (count_q == '0);

  // Next count: restart on clear, otherwise advance until the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-sweep sequencer: for each table point fetch the NCO increment,
// load the NCO, settle, run the phase/magnitude detector and write results.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned INC_WIDTH     = DEF_INC_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MEAS_TIMEOUT  = DEF_MEAS_TIMEOUT,
  parameter int unsigned ROM_LATENCY   = DEF_ROM_LATENCY
) (
  input  logic                  clk125,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] freq_addr,
  input  logic [INC_WIDTH-1:0]  rom_inc,
  output logic [INC_WIDTH-1:0]  phase_inc,
  output logic                  nco_load,
  output logic                  meas_start,
  input  logic                  meas_done,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  result_wren,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  timeout_err
);

  localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES, MEAS_TIMEOUT, ROM_LATENCY);

  // The LOAD cycle is the first settle cycle, so the SETTLE state itself lasts
  // SETTLE_CYCLES-1 cycles and is skipped entirely when SETTLE_CYCLES is 1.
  localparam logic [CNT_W-1:0] FETCH_LIM  = CNT_W'(ROM_LATENCY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] MEAS_LIM   = CNT_W'(MEAS_TIMEOUT - 1);

  sweep_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] result_addr_q, result_addr_d;
  logic [INC_WIDTH-1:0]  phase_inc_q, phase_inc_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  aborted_q, aborted_d;

  logic                  timer_clear;
  logic [CNT_W-1:0]      timer_limit;
  logic                  timer_expired;
  logic                  timer_first;

  cycle_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk     (clk125),
    .reset   (reset),
    .clear   (timer_clear),
    .limit   (timer_limit),
    .expired (timer_expired),
    .first   (timer_first)
  );

  // Every state change restarts the wait counter.
  assign timer_clear = (state_d != state_q);

  // Select the wait length for the current state.
  always_comb begin
    timer_limit = '0;
    case (state_q)
      FETCH:   timer_limit = FETCH_LIM;
      SETTLE:  timer_limit = SETTLE_LIM;
      MEAS:    timer_limit = MEAS_LIM;
      default: timer_limit = '0;
    endcase
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    last_d        = last_q;
    result_addr_d = result_addr_q;
    phase_inc_d   = phase_inc_q;
    timeout_err_d = timeout_err_q;
    aborted_d     = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        state_d       = FETCH;
        index_d       = '0;
        last_d        = last_addr;
        timeout_err_d = 1'b0;
      end
    end else if (abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (timer_expired) state_d = LOAD;
        end
        LOAD: begin
          phase_inc_d = rom_inc;
          state_d     = (SETTLE_CYCLES > 1) ? SETTLE : MEAS;
        end
        SETTLE: begin
          if (timer_expired) state_d = MEAS;
        end
        MEAS: begin
          // A result flagged in the meas_start cycle belongs to the previous point.
          if (meas_done && !timer_first) begin
            state_d       = WRITE;
            result_addr_d = index_q;
          end else if (timer_expired) begin
            state_d       = WRITE;
            result_addr_d = index_q;
            timeout_err_d = 1'b1;
          end
        end
        WRITE: begin
          state_d = NEXT;
        end
        NEXT: begin
          if (index_q == last_q) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = FETCH;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      last_q        <= '0;
      result_addr_q <= '0;
      phase_inc_q   <= '0;
      timeout_err_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      last_q        <= last_d;
      result_addr_q <= result_addr_d;
      phase_inc_q   <= phase_inc_d;
      timeout_err_q <= timeout_err_d;
      aborted_q     <= aborted_d;
    end
  end

  assign freq_addr   = index_q;
  assign result_addr = result_addr_q;
  assign phase_inc   = phase_inc_q;
  assign nco_load    = (state_q == LOAD) && !abort;
  assign meas_start  = (state_q == MEAS) && timer_first;
  assign result_wren = (state_q == WRITE) && !abort;
  assign done        = (state_q == DONE) && !abort;
  assign busy        = (state_q != IDLE);
  assign aborted     = aborted_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer with a registered ROM model and a
// fixed-delay detector model.
module tb_sweep_sequencer;

  localparam int AW = 8;
  localparam int IW = 32;
  localparam int SC = 4;
  localparam int MT = 8;
  localparam int RL = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] inc;
    int            lat;
  } exp_t;

  logic          clk125 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] freq_addr;
  logic [IW-1:0] rom_inc;
  logic [IW-1:0] phase_inc;
  logic          nco_load;
  logic          meas_start;
  logic          meas_done;
  logic [AW-1:0] result_addr;
  logic          result_wren;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          timeout_err;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;
  int   last_ms_cyc = 0;
  int   last_nco_cyc = 0;
  int   n_wren = 0;
  int   n_done = 0;
  int   n_abort = 0;

  int   det_delay = 3;
  logic det_en = 1'b1;
  logic det_force = 1'b0;
  int   det_p = 0;
  logic [AW-1:0] rom_a_q;

  always #4 clk125 = ~clk125;

  sweep_sequencer #(
    .ADDR_WIDTH    (AW),
    .INC_WIDTH     (IW),
    .SETTLE_CYCLES (SC),
    .MEAS_TIMEOUT  (MT),
    .ROM_LATENCY   (RL)
  ) dut (
    .clk125      (clk125),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .last_addr   (last_addr),
    .freq_addr   (freq_addr),
    .rom_inc     (rom_inc),
    .phase_inc   (phase_inc),
    .nco_load    (nco_load),
    .meas_start  (meas_start),
    .meas_done   (meas_done),
    .result_addr (result_addr),
    .result_wren (result_wren),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .timeout_err (timeout_err)
  );

  function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
    return 32'h1357_0000 ^ {a, 8'h5A, ~a, a};
  endfunction

  // ROM: registered address then registered data (two-cycle latency).
  always @(posedge clk125) begin
    rom_a_q <= freq_addr;
    rom_inc <= rom_f(rom_a_q);
  end

  // Detector: result valid det_delay cycles after meas_start.
  always @(posedge clk125) begin
    cyc <= cyc + 1;
    if (meas_start) det_p <= det_delay;
    else if (det_p != 0) det_p <= det_p - 1;
  end
  assign meas_done = (det_en && det_p == 1) || det_force;

  // Monitor: settle spacing and scoreboard of result writes.
  always @(negedge clk125) begin
    exp_t e;
    if (nco_load) last_nco_cyc = cyc;
    if (meas_start) begin
      last_ms_cyc = cyc;
      chk_cnt++;
      if (cyc - last_nco_cyc !== SC)
        $display("FAIL settle_gap: got %0d cycles, expected %0d", cyc - last_nco_cyc, SC);
      else pass_cnt++;
    end
    if (done) n_done++;
    if (aborted) n_abort++;
    if (result_wren) begin
      n_wren++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_wren: addr %0d, expected no write", result_addr);
      end else begin
        pass_cnt++;
        e = exp_q.pop_front();
        chk_cnt++;
        if (result_addr !== e.addr)
          $display("FAIL wr_addr: got %0d, expected %0d", result_addr, e.addr);
        else pass_cnt++;
        chk_cnt++;
        if (phase_inc !== e.inc)
          $display("FAIL wr_phase_inc: got %h, expected %h", phase_inc, e.inc);
        else pass_cnt++;
        chk_cnt++;
        if (cyc - last_ms_cyc !== e.lat)
          $display("FAIL wr_latency: got %0d, expected %0d", cyc - last_ms_cyc, e.lat);
        else pass_cnt++;
      end
    end
  end

  task automatic push_points(input int last, input int lat);
    exp_t e;
    for (int i = 0; i <= last; i++) begin
      e.addr = AW'(i);
      e.inc  = rom_f(AW'(i));
      e.lat  = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_sweep(input logic [AW-1:0] l);
    @(negedge clk125);
    last_addr = l;
    start = 1'b1;
    @(posedge clk125);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk125);
      k++;
    end
    chk_cnt++;
    if (busy) $display("FAIL %s_wait: still busy after %0d cycles, expected idle", name, budget);
    else pass_cnt++;
    repeat (2) @(negedge clk125);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk125);
    #1 reset = 1'b0;
    @(negedge clk125);
    chk_cnt++; if (freq_addr !== '0) $display("FAIL rst_freq_addr: got %0d, expected 0", freq_addr); else pass_cnt++;
    chk_cnt++; if (result_addr !== '0) $display("FAIL rst_result_addr: got %0d, expected 0", result_addr); else pass_cnt++;
    chk_cnt++; if (phase_inc !== '0) $display("FAIL rst_phase_inc: got %h, expected 0", phase_inc); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else pass_cnt++;
    chk_cnt++;
    if ({nco_load, meas_start, result_wren, done, aborted} !== 5'b0)
      $display("FAIL rst_pulses: got %b, expected 00000", {nco_load, meas_start, result_wren, done, aborted});
    else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b, expected 0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_sweep_basic();
    int w0 = n_wren, d0 = n_done, a0 = n_abort;
    push_points(2, det_delay + 1);
    start_sweep(2);
    wait_idle(500, "basic");
    chk_cnt++; if (n_wren - w0 !== 3) $display("FAIL basic_writes: got %0d, expected 3", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 1) $display("FAIL basic_done: got %0d, expected 1", n_done - d0); else pass_cnt++;
    chk_cnt++; if (n_abort - a0 !== 0) $display("FAIL basic_aborted: got %0d, expected 0", n_abort - a0); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL basic_timeout_err: got %b, expected 0", timeout_err); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL basic_pending: got %0d, expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_start_timing();
    int c0;
    int nco_at = -1;
    int ms_at = -1;
    push_points(0, det_delay + 1);
    @(negedge clk125);
    c0 = cyc;
    last_addr = '0;
    start = 1'b1;
    @(posedge clk125);
    #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk125);
      if (nco_load && nco_at < 0) nco_at = cyc - c0;
      if (meas_start && ms_at < 0) ms_at = cyc - c0;
    end
    chk_cnt++; if (nco_at !== RL + 1) $display("FAIL timing_nco_load: got %0d, expected %0d", nco_at, RL + 1); else pass_cnt++;
    chk_cnt++; if (ms_at !== RL + 1 + SC) $display("FAIL timing_meas_start: got %0d, expected %0d", ms_at, RL + 1 + SC); else pass_cnt++;
    wait_idle(200, "timing");
  endtask

  task automatic test_timeout();
    int w0 = n_wren, d0 = n_done;
    det_en = 1'b0;
    push_points(0, MT);
    start_sweep(0);
    wait_idle(200, "timeout");
    chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_set: got %b, expected 1", timeout_err); else pass_cnt++;
    chk_cnt++; if (n_wren - w0 !== 1) $display("FAIL timeout_writes: got %0d, expected 1", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 1) $display("FAIL timeout_done: got %0d, expected 1", n_done - d0); else pass_cnt++;
    repeat (5) @(negedge clk125);
    chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b, expected 1", timeout_err); else pass_cnt++;
    det_en = 1'b1;
  endtask

  task automatic test_timeout_clear();
    push_points(0, det_delay + 1);
    start_sweep(0);
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL terr_clear_start: got %b, expected 0", timeout_err); else pass_cnt++;
    wait_idle(200, "terr_clear");
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL terr_clear_end: got %b, expected 0", timeout_err); else pass_cnt++;
  endtask

  task automatic test_abort();
    int w0 = n_wren, d0 = n_done, a0 = n_abort;
    int seen = 0;
    int k = 0;
    push_points(0, det_delay + 1);
    start_sweep(5);
    while (seen < 2 && k < 300) begin
      @(negedge clk125);
      if (nco_load) seen++;
      k++;
    end
    chk_cnt++; if (seen !== 2) $display("FAIL abort_reach_point1: got %0d loads, expected 2", seen); else pass_cnt++;
    @(negedge clk125);
    abort = 1'b1;
    @(posedge clk125);
    #1 abort = 1'b0;
    @(negedge clk125);
    chk_cnt++; if (aborted !== 1'b1) $display("FAIL abort_pulse: got %b, expected 1", aborted); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", busy); else pass_cnt++;
    chk_cnt++; if (phase_inc !== rom_f(1)) $display("FAIL abort_phase_inc: got %h, expected %h", phase_inc, rom_f(1)); else pass_cnt++;
    @(negedge clk125);
    chk_cnt++; if (aborted !== 1'b0) $display("FAIL abort_one_cycle: got %b, expected 0", aborted); else pass_cnt++;
    repeat (30) @(negedge clk125);
    chk_cnt++; if (n_wren - w0 !== 1) $display("FAIL abort_writes: got %0d, expected 1", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 0) $display("FAIL abort_done: got %0d, expected 0", n_done - d0); else pass_cnt++;
    chk_cnt++; if (n_abort - a0 !== 1) $display("FAIL abort_count: got %0d, expected 1", n_abort - a0); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL abort_pending: got %0d, expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_start_abort_idle();
    int w0, d0;
    @(negedge clk125);
    abort = 1'b1;
    @(posedge clk125);
    #1 abort = 1'b0;
    @(negedge clk125);
    chk_cnt++; if (aborted !== 1'b0) $display("FAIL idle_abort_pulse: got %b, expected 0", aborted); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_abort_busy: got %b, expected 0", busy); else pass_cnt++;
    w0 = n_wren;
    d0 = n_done;
    push_points(0, det_delay + 1);
    @(negedge clk125);
    last_addr = '0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk125);
    #1 start = 1'b0;
    abort = 1'b0;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL start_abort_busy: got %b, expected 1", busy); else pass_cnt++;
    wait_idle(200, "start_abort");
    chk_cnt++; if (n_wren - w0 !== 1) $display("FAIL start_abort_writes: got %0d, expected 1", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 1) $display("FAIL start_abort_done: got %0d, expected 1", n_done - d0); else pass_cnt++;
  endtask

  task automatic test_abort_meas_done();
    int w0 = n_wren, d0 = n_done;
    int k = 0;
    start_sweep(0);
    while (!meas_done && k < 100) begin
      @(negedge clk125);
      k++;
    end
    chk_cnt++; if (meas_done !== 1'b1) $display("FAIL amd_reach: got %b, expected 1", meas_done); else pass_cnt++;
    abort = 1'b1;
    @(posedge clk125);
    #1 abort = 1'b0;
    @(negedge clk125);
    chk_cnt++; if (result_wren !== 1'b0) $display("FAIL amd_wren: got %b, expected 0", result_wren); else pass_cnt++;
    chk_cnt++; if (aborted !== 1'b1) $display("FAIL amd_aborted: got %b, expected 1", aborted); else pass_cnt++;
    repeat (10) @(negedge clk125);
    chk_cnt++; if (n_wren - w0 !== 0) $display("FAIL amd_writes: got %0d, expected 0", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 0) $display("FAIL amd_done: got %0d, expected 0", n_done - d0); else pass_cnt++;
  endtask

  task automatic test_same_cycle_done();
    int w0 = n_wren;
    int k = 0;
    push_points(0, det_delay + 1);
    start_sweep(0);
    while (!meas_start && k < 100) begin
      @(negedge clk125);
      k++;
    end
    chk_cnt++; if (meas_start !== 1'b1) $display("FAIL same_reach: got %b, expected 1", meas_start); else pass_cnt++;
    det_force = 1'b1;
    @(posedge clk125);
    #1 det_force = 1'b0;
    wait_idle(200, "same_cycle");
    chk_cnt++; if (n_wren - w0 !== 1) $display("FAIL same_writes: got %0d, expected 1", n_wren - w0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w0 = n_wren;
    int seen = 0;
    int k = 0;
    push_points(0, det_delay + 1);
    push_points(0, det_delay + 1);
    @(negedge clk125);
    last_addr = '0;
    start = 1'b1;
    while (seen < 2 && k < 200) begin
      @(negedge clk125);
      if (done) seen++;
      k++;
    end
    start = 1'b0;
    chk_cnt++; if (seen !== 2) $display("FAIL b2b_done: got %0d, expected 2", seen); else pass_cnt++;
    repeat (3) @(negedge clk125);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b, expected 0", busy); else pass_cnt++;
    chk_cnt++; if (n_wren - w0 !== 2) $display("FAIL b2b_writes: got %0d, expected 2", n_wren - w0); else pass_cnt++;
  endtask

  task automatic test_full_table();
    int w0 = n_wren, d0 = n_done;
    push_points(255, det_delay + 1);
    start_sweep(8'd255);
    wait_idle(5000, "full");
    chk_cnt++; if (n_wren - w0 !== 256) $display("FAIL full_writes: got %0d, expected 256", n_wren - w0); else pass_cnt++;
    chk_cnt++; if (result_addr !== 8'd255) $display("FAIL full_result_addr: got %0d, expected 255", result_addr); else pass_cnt++;
    chk_cnt++; if (freq_addr !== 8'd255) $display("FAIL full_freq_addr: got %0d, expected 255", freq_addr); else pass_cnt++;
    chk_cnt++; if (n_done - d0 !== 1) $display("FAIL full_done: got %0d, expected 1", n_done - d0); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL full_pending: got %0d, expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0 = n_done, a0 = n_abort;
    int seen = 0;
    int k = 0;
    push_points(0, det_delay + 1);
    start_sweep(3);
    while (seen < 2 && k < 200) begin
      @(negedge clk125);
      if (meas_start) seen++;
      k++;
    end
    chk_cnt++; if (seen !== 2) $display("FAIL rmid_reach: got %0d, expected 2", seen); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk125);
    #1 reset = 1'b0;
    @(negedge clk125);
    chk_cnt++; if (freq_addr !== '0) $display("FAIL rmid_freq_addr: got %0d, expected 0", freq_addr); else pass_cnt++;
    chk_cnt++; if (result_addr !== '0) $display("FAIL rmid_result_addr: got %0d, expected 0", result_addr); else pass_cnt++;
    chk_cnt++; if (phase_inc !== '0) $display("FAIL rmid_phase_inc: got %h, expected 0", phase_inc); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b, expected 0", busy); else pass_cnt++;
    chk_cnt++;
    if ({nco_load, meas_start, result_wren, done, aborted, timeout_err} !== 6'b0)
      $display("FAIL rmid_pulses: got %b, expected 000000", {nco_load, meas_start, result_wren, done, aborted, timeout_err});
    else pass_cnt++;
    repeat (10) @(negedge clk125);
    chk_cnt++; if (n_done - d0 !== 0) $display("FAIL rmid_done: got %0d, expected 0", n_done - d0); else pass_cnt++;
    chk_cnt++; if (n_abort - a0 !== 0) $display("FAIL rmid_aborted: got %0d, expected 0", n_abort - a0); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL rmid_pending: got %0d, expected 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sweep_basic();
    test_start_timing();
    test_timeout();
    test_timeout_clear();
    test_abort();
    test_start_abort_idle();
    test_abort_meas_done();
    test_same_cycle_done();
    test_back_to_back();
    test_full_table();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
